ula_pipe: RTL and testbench

ULA_PIPE -- requirements
Module: ula_pipe

---
 rtl/ula_pipe.sv | 141 ++++++++++++++
 tb/tb_ula_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_pipe.sv
`default_nettype none
// ============================================================================
// ula_pipe : two-stage pipelined ALU (logic/arithmetic groups) with a global
//            valid/ready stall and sticky overflow. Macro ULA_SAT_EN enables
//            signed saturation of overflowing arithmetic results.
// Revision : 1.0
// ============================================================================
module ula_pipe #(
  parameter int WIDTH = 6
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_modo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_neg,
  input  logic             clr_sticky,
  output logic             ovf_sticky
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_modo;
  logic             advance;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Every arithmetic op is one adder pass x + y + cin. Decrements add -1 at
  // WIDTH+1 bits (carry reads as borrow); A-B style ops use A+~B+1 (carry
  // reads as no-borrow).
  always_comb begin
    x   = s1_a;
    y   = s1_b;
    cin = 1'b0;
    ext = 1'b0;
    case (s1_op)
      3'd0: cin = 1'b0;
      3'd1: begin y = ~s1_b; cin = 1'b1; end
      3'd2: y = ~s1_b;
      3'd3: cin = 1'b1;
      3'd4: begin y = '0; cin = 1'b1; end
      3'd5: begin y = '1; ext = 1'b1; end
      3'd6: begin x = s1_b; y = '0; cin = 1'b1; end
      default: begin x = s1_b; y = '1; ext = 1'b1; end
    endcase
  end

  assign sum = {1'b0, x} + {ext, y} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    res   = sum[WIDTH-1:0];
    carry = sum[WIDTH];
    ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    if (s1_modo) begin
      carry = 1'b0;
      ovf   = 1'b0;
      case (s1_op)
        3'd0: res = s1_a & s1_b;
        3'd1: res = ~s1_a;
        3'd2: res = ~s1_b;
        3'd3: res = s1_a | s1_b;
        3'd4: res = s1_a ^ s1_b;
        3'd5: res = ~(s1_a & s1_b);
        3'd6: res = s1_a;
        default: res = s1_b;
      endcase
    end
`ifdef ULA_SAT_EN
    // On overflow both addends share x's sign, so it is the sign of the true result.
    if (!s1_modo && ovf) begin
      res = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_modo    <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      out_neg    <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_op   <= in_op;
        s1_modo <= in_modo;
      end
      if (s1_valid) begin
        out_result <= res;
        out_zero   <= (res == '0);
        out_carry  <= carry;
        out_ovf    <= ovf;
        out_neg    <= res[WIDTH-1];
      end
    end
  end

  // A delivered overflow wins over a simultaneous clear.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && out_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ula_pipe.sv
`default_nettype none
// ============================================================================
// tb_ula_pipe : random + directed checks of ula_pipe at WIDTH=6 and WIDTH=16
//               against an integer-arithmetic reference model and scoreboard.
// Revision : 1.0
// ============================================================================
module tb_ula_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;  // {zero, carry, ovf, neg}
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, out_ready, clr_sticky, in_modo;
  logic [2:0]  in_op;
  logic [5:0]  a6, b6;
  logic [15:0] a16, b16;

  logic        in_ready6, out_valid6, zero6, carry6, ovf6, neg6, sticky6;
  logic [5:0]  res6;
  logic        in_ready16, out_valid16, zero16, carry16, ovf16, neg16, sticky16;
  logic [15:0] res16;

  ula_pipe #(.WIDTH(6)) dut6 (
    .CLOCK_50(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready6),
    .in_a(a6), .in_b(b6), .in_op(in_op), .in_modo(in_modo),
    .out_valid(out_valid6), .out_ready(out_ready), .out_result(res6),
    .out_zero(zero6), .out_carry(carry6), .out_ovf(ovf6), .out_neg(neg6),
    .clr_sticky(clr_sticky), .ovf_sticky(sticky6)
  );

  ula_pipe #(.WIDTH(16)) dut16 (
    .CLOCK_50(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(a16), .in_b(b16), .in_op(in_op), .in_modo(in_modo),
    .out_valid(out_valid16), .out_ready(out_ready), .out_result(res16),
    .out_zero(zero16), .out_carry(carry16), .out_ovf(ovf16), .out_neg(neg16),
    .clr_sticky(clr_sticky), .ovf_sticky(sticky16)
  );

  int          total, bad;
  exp_t        q6[$], q16[$];
  logic        exp_st6, exp_st16;
  logic        prev_stall6, prev_stall16;
  logic [5:0]  prev_r6;
  logic [15:0] prev_r16;
  logic [1:0]  hist;
  bit          free_run;

  // Reference: true signed value decides overflow, unsigned sum at w+1 bits gives carry.
  function automatic exp_t model(input int w, input longint unsigned a,
                                 input longint unsigned b, input logic [2:0] op,
                                 input logic modo);
    longint unsigned m, u;
    longint          sa, sb, s, smax, smin;
    logic            z, c, v, n;
    exp_t            e;
    m    = (64'd1 << w) - 64'd1;
    smax = longint'(m >> 1);
    smin = -smax - 1;
    sa   = (a > (m >> 1)) ? longint'(a) - longint'(m) - 1 : longint'(a);
    sb   = (b > (m >> 1)) ? longint'(b) - longint'(m) - 1 : longint'(b);
    u = 0; s = 0; c = 1'b0; v = 1'b0;
    if (modo) begin
      case (op)
        3'd0: u = a & b;
        3'd1: u = ~a;
        3'd2: u = ~b;
        3'd3: u = a | b;
        3'd4: u = a ^ b;
        3'd5: u = ~(a & b);
        3'd6: u = a;
        default: u = b;
      endcase
      u = u & m;
    end else begin
      case (op)
        3'd0: begin u = a + b;           s = sa + sb;     end
        3'd1: begin u = a + (m - b) + 1; s = sa - sb;     end
        3'd2: begin u = a + (m - b);     s = sa - sb - 1; end
        3'd3: begin u = a + b + 1;       s = sa + sb + 1; end
        3'd4: begin u = a + 1;           s = sa + 1;      end
        3'd5: begin u = a + 2 * m + 1;   s = sa - 1;      end
        3'd6: begin u = b + 1;           s = sb + 1;      end
        default: begin u = b + 2 * m + 1; s = sb - 1;     end
      endcase
      c = ((u >> w) & 64'd1) != 0;
      v = (s > smax) || (s < smin);
      u = u & m;
`ifdef ULA_SAT_EN
      if (v) u = (s > 0) ? (m >> 1) : (m >> 1) + 1;
`endif
    end
    z = (u == 0);
    n = ((u >> (w - 1)) & 64'd1) != 0;
    e.res   = 32'(u);
    e.flags = {z, c, v, n};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven at the falling edge; sample 1 time unit later.
  task automatic step();
    exp_t e;
    logic xo;
    #1;
    check("sticky6", 32'(sticky6), 32'(exp_st6));
    check("sticky16", 32'(sticky16), 32'(exp_st16));
    check("in_ready6", 32'(in_ready6), 32'(!(out_valid6 && !out_ready)));
    check("in_ready16", 32'(in_ready16), 32'(!(out_valid16 && !out_ready)));
    if (free_run) begin
      check("latency6", 32'(out_valid6), 32'(hist[1]));
      check("latency16", 32'(out_valid16), 32'(hist[1]));
    end
    if (prev_stall6) begin
      check("hold_valid6", 32'(out_valid6), 32'd1);
      check("hold_res6", 32'(res6), 32'(prev_r6));
    end
    if (prev_stall16) begin
      check("hold_valid16", 32'(out_valid16), 32'd1);
      check("hold_res16", 32'(res16), 32'(prev_r16));
    end
    if (out_valid6 && out_ready) begin
      xo = 1'b0;
      if (q6.size() == 0) check("stray6", 32'(out_valid6), 32'd0);
      else begin
        e = q6.pop_front();
        check("res6", 32'(res6), e.res);
        check("flags6", {28'd0, zero6, carry6, ovf6, neg6}, {28'd0, e.flags});
        xo = e.flags[1];
      end
      exp_st6 = xo ? 1'b1 : (clr_sticky ? 1'b0 : exp_st6);
    end else if (clr_sticky) exp_st6 = 1'b0;
    if (out_valid16 && out_ready) begin
      xo = 1'b0;
      if (q16.size() == 0) check("stray16", 32'(out_valid16), 32'd0);
      else begin
        e = q16.pop_front();
        check("res16", 32'(res16), e.res);
        check("flags16", {28'd0, zero16, carry16, ovf16, neg16}, {28'd0, e.flags});
        xo = e.flags[1];
      end
      exp_st16 = xo ? 1'b1 : (clr_sticky ? 1'b0 : exp_st16);
    end else if (clr_sticky) exp_st16 = 1'b0;
    if (in_valid && in_ready6)  q6.push_back(model(6, a6, b6, in_op, in_modo));
    if (in_valid && in_ready16) q16.push_back(model(16, a16, b16, in_op, in_modo));
    hist         = {hist[0], in_valid && in_ready6};
    prev_stall6  = out_valid6 && !out_ready;
    prev_stall16 = out_valid16 && !out_ready;
    prev_r6      = res6;
    prev_r16     = res16;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic v, input logic modo, input logic [2:0] op,
                       input logic [5:0] a, input logic [5:0] b,
                       input logic [15:0] wa, input logic [15:0] wb);
    in_valid = v; in_modo = modo; in_op = op;
    a6 = a; b6 = b; a16 = wa; b16 = wb;
    step();
  endtask

  task automatic rand_in(input logic v);
    in_valid = v;
    in_modo  = 1'($urandom);
    in_op    = 3'($urandom);
    a6  = 6'($urandom);  b6  = 6'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12 && (q6.size() != 0 || q16.size() != 0); i++) step();
    check("drain6", q6.size(), 32'd0);
    check("drain16", q16.size(), 32'd0);
    step();
    step();
  endtask

  task automatic check_cleared();
    check("rst_valid6", 32'(out_valid6), 32'd0);
    check("rst_valid16", 32'(out_valid16), 32'd0);
    check("rst_ready6", 32'(in_ready6), 32'd1);
    check("rst_ready16", 32'(in_ready16), 32'd1);
    check("rst_res6", 32'(res6), 32'd0);
    check("rst_res16", 32'(res16), 32'd0);
    check("rst_flags6", {28'd0, zero6, carry6, ovf6, neg6}, 32'd0);
    check("rst_flags16", {28'd0, zero16, carry16, ovf16, neg16}, 32'd0);
    check("rst_sticky6", 32'(sticky6), 32'd0);
    check("rst_sticky16", 32'(sticky16), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    in_op = '0; in_modo = 1'b0; a6 = '0; b6 = '0; a16 = '0; b16 = '0;
    exp_st6 = 1'b0; exp_st16 = 1'b0; prev_stall6 = 1'b0; prev_stall16 = 1'b0;
    prev_r6 = '0; prev_r16 = '0; hist = '0; free_run = 1'b0;

    repeat (2) @(negedge clk);
    #1 check_cleared();
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1; free_run = 1'b1;

    // Directed arithmetic/logic vectors, back-to-back.
    issue(1, 0, 3'd0, 6'd31, 6'd1,  16'h7fff, 16'h0001);
    issue(1, 0, 3'd1, 6'd5,  6'd5,  16'h1234, 16'h1234);
    issue(1, 0, 3'd5, 6'd0,  6'd9,  16'h0000, 16'h0003);
    issue(1, 1, 3'd5, 6'd63, 6'd63, 16'hffff, 16'hffff);
    issue(1, 0, 3'd5, 6'd32, 6'd0,  16'h8000, 16'h0000);
    issue(1, 0, 3'd7, 6'd3,  6'd0,  16'h0000, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      rand_in(1'b1);
      in_modo = 1'b1;
      step();
    end
    for (int i = 0; i < 40; i++) begin
      rand_in($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Backpressure: consumer stalls for 5 cycles while ops keep arriving.
    free_run = 1'b0;
    out_ready = 1'b0;
    rand_in(1'b1);
    for (int i = 0; i < 5; i++) begin
      int n;
      n = q6.size();
      step();
      if (q6.size() != n) rand_in(1'b1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_in(1'b1);
      step();
    end
    drain();

    // Random traffic with random backpressure and sticky clears.
    for (int i = 0; i < 150; i++) begin
      rand_in($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 1) == 1);
      clr_sticky = ($urandom_range(0, 7) == 0);
      step();
    end
    clr_sticky = 1'b0;
    drain();
    free_run = 1'b1;

    // Overflow delivered while clearing: set wins, then the next clear takes effect.
    clr_sticky = 1'b1;
    step();
    issue(1, 0, 3'd0, 6'd31, 6'd1, 16'h7fff, 16'h0001);
    in_valid = 1'b0;
    step();
    check("sticky_pre6", 32'(sticky6), 32'd0);
    step();
    check("sticky_win6", 32'(sticky6), 32'd1);
    check("sticky_win16", 32'(sticky16), 32'd1);
    step();
    check("sticky_clr6", 32'(sticky6), 32'd0);
    check("sticky_clr16", 32'(sticky16), 32'd0);
    clr_sticky = 1'b0;

    // Reset with two ops in flight and the sticky flag set.
    issue(1, 0, 3'd4, 6'd31, 6'd0, 16'h7fff, 16'h0000);
    in_valid = 1'b0;
    step();
    step();
    issue(1, 1, 3'd4, 6'd21, 6'd42, 16'h00ff, 16'h0f0f);
    issue(1, 0, 3'd0, 6'd10, 6'd20, 16'h1000, 16'h2000);
    in_valid = 1'b0;
    check("pre_rst_valid6", 32'(out_valid6), 32'd1);
    check("pre_rst_sticky6", 32'(sticky6), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_cleared();
    q6.delete(); q16.delete();
    exp_st6 = 1'b0; exp_st16 = 1'b0; hist = '0;
    prev_stall6 = 1'b0; prev_stall16 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(1, 0, 3'd1, 6'd7, 6'd9, 16'h0001, 16'h0002);
    in_valid = 1'b0;
    step();
    step();
    step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
